// File: rtl/adder_if.sv
// Operand/result bundle for the four-operand adder.
//   a, b, c, d : 4-bit unsigned operands (driven by master)
//   sum        : registered low 4 bits of a+b+c+d (driven by slave)
//   ov         : registered overflow flag, set when a+b+c+d > 15 (driven by slave)
interface adder_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] sum;
    logic       ov;

    modport master (
        output a,
        output b,
        output c,
        output d,
        input  sum,
        input  ov
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        input  d,
        output sum,
        output ov
    );
endinterface : adder_if

// File: rtl/adder.sv
// Registered four-operand unsigned adder with wrapped 4-bit sum and overflow flag.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : adder_if.slave -- operands a..d in, registered sum/ov out
module adder (
    input  logic    clk,
    input  logic    rst,
    adder_if.slave  bus
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PAIR_W = OP_W + 1;
    localparam int unsigned TOT_W  = OP_W + 2;

    logic [PAIR_W-1:0] ab_sum;
    logic [PAIR_W-1:0] cd_sum;
    logic [TOT_W-1:0]  total;

    logic [OP_W-1:0] sum_d;
    logic [OP_W-1:0] sum_q;
    logic            ov_d;
    logic            ov_q;

    // Two-level adder tree; full-precision total feeds wrap and overflow.
    always_comb begin
        ab_sum = PAIR_W'(bus.a) + PAIR_W'(bus.b);
        cd_sum = PAIR_W'(bus.c) + PAIR_W'(bus.d);
        total  = TOT_W'(ab_sum) + TOT_W'(cd_sum);
        sum_d  = total[OP_W-1:0];
        ov_d   = |total[TOT_W-1:OP_W];
    end

    // Output registers; reset wins over the operand update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ov_q  <= ov_d;
        end
    end

    assign bus.sum = sum_q;
    assign bus.ov  = ov_q;

endmodule : adder

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed boundaries, reset cases, a latency
// sweep with a one-edge mid-stream reset, random vectors and an exhaustive pass.
module tb_adder;

    logic clk;
    logic rst;

    adder_if bus_if ();

    adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive operands and reset level, take one edge, compare against arithmetic model.
    task automatic step(input int a, input int b, input int c, input int d,
                        input logic r, input string tag);
        int s;
        int exp_sum;
        int exp_ov;
        bus_if.a = 4'(a);
        bus_if.b = 4'(b);
        bus_if.c = 4'(c);
        bus_if.d = 4'(d);
        rst      = r;
        @(posedge clk);
        #1;
        s = (a % 16) + (b % 16) + (c % 16) + (d % 16);
        if (!r) begin
            exp_sum = 0;
            exp_ov  = 0;
        end else begin
            exp_sum = s % 16;
            exp_ov  = (s > 15) ? 1 : 0;
        end
        check_eq({tag, "_sum"}, int'(bus_if.sum), exp_sum);
        check_eq({tag, "_ov"},  int'(bus_if.ov),  exp_ov);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        bus_if.a = 4'd0;
        bus_if.b = 4'd0;
        bus_if.c = 4'd0;
        bus_if.d = 4'd0;

        // Reset held two edges with all-ones operands, then release.
        step(15, 15, 15, 15, 1'b0, "rst0");
        step(15, 15, 15, 15, 1'b0, "rst1");
        step(15, 15, 15, 15, 1'b1, "rel60");

        // Directed values and boundaries.
        step(3, 4, 5, 2,   1'b1, "s14");
        step(15, 0, 0, 0,  1'b1, "s15");
        step(15, 1, 0, 0,  1'b1, "s16");
        step(8, 8, 8, 8,   1'b1, "s32");
        step(0, 0, 0, 0,   1'b1, "s0");
        step(15, 15, 15, 15, 1'b1, "s60");

        // Latency sweep: a increments, d random, one-edge reset in the middle.
        for (int i = 0; i < 16; i++) begin
            step(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), (i == 7) ? 1'b0 : 1'b1, "sweep");
        end

        // Random vectors with occasional reset.
        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1, "rand");
        end

        // Exhaustive operand space, one combination per cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 16; c++) begin
                    for (int d = 0; d < 16; d++) begin
                        step(a, b, c, d, 1'b1, "exh");
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_adder

// File: doc/adder.md
# adder

Registered four-operand unsigned adder. It sums four 4-bit operands each clock cycle and presents a 4-bit wrapped sum with an overflow flag. The block is a small arithmetic leaf in the digital-systems lab datapath and is exercised by counter/random stimulus benches. Outputs are registered, with a synchronous active-low reset.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; one clock, reset sampled on the rising edge of clk.
- a  input  4  unsigned operand 0, range 0..15.
- b  input  4  unsigned operand 1, range 0..15.
- c  input  4  unsigned operand 2, range 0..15.
- d  input  4  unsigned operand 3, range 0..15.
- sum  output  4  registered low 4 bits of a+b+c+d.
- ov  output  1  registered overflow flag: 1 when the true sum of a+b+c+d exceeds 15.

## Operation
- Full-precision sum S = a + b + c + d is computed unsigned in 6 bits, range 0..60; no operand is sign-extended.
- Structure: two-level adder tree; (a+b) and (c+d) are each 5 bits, and their total is 6 bits. Any equivalent structure is acceptable if results are bit-exact.
- sum_next = S[3:0], which is S mod 16 (wrap-around).
- ov_next = |S[5:4], which is 1 exactly when S >= 16.
- On every rising clk edge with rst = 1: sum <= sum_next and ov <= ov_next.
- On every rising clk edge with rst = 0: sum <= 0 and ov <= 0, regardless of operand values. Reset has priority over the operand update.
- No enable, no handshake, no internal state other than the output registers.
- Inputs are sampled every cycle; there is no hold or stall behaviour.
- X or Z on any operand bit may propagate to the outputs; no X-masking is required.

## Timing
- Latency is 1 cycle: operands present at rising edge N appear on sum/ov after edge N and hold until edge N+1.
- Throughput is one new result per cycle.
- The combinational path (operand inputs to the register D inputs) must close at the lab clock.
- Reset:
  - sum = 0 and ov = 0 after the first rising edge sampled with rst = 0.
  - Before any edge, outputs are unspecified (simulation X allowed).
  - rst is not in any sensitivity list; asserting rst between edges has no effect until the next rising edge.
- Reset mid-stream: the edge that samples rst = 0 discards that cycle's operands. The first edge with rst = 1 again registers the operands present at that edge.
- Boundaries:
  - S = 15 gives sum = 15, ov = 0.
  - S = 16 gives sum = 0, ov = 1.
  - S = 60 gives sum = 12, ov = 1.
  - S = 0 gives sum = 0, ov = 0.

## Test plan
- Reset: hold rst = 0 for 2 edges with a=b=c=d=15. Required: sum = 0, ov = 0; release rst, and at the next edge sum = 12, ov = 1.
- No overflow: a=3, b=4, c=5, d=2. Required: one edge later sum = 14, ov = 0; then a=15, b=c=d=0 gives sum = 15, ov = 0.
- Wrap boundary: a=15, b=1, c=0, d=0. Required: sum = 0, ov = 1; then a=8, b=8, c=8, d=8 (S=32) gives sum = 0, ov = 1.
- Latency: change operands every cycle (a increments 0..15, d random). Required: each cycle's registered output equals the golden model of the previous edge's operands, with no skipped or duplicated results.
- Reset mid-operation: during the increment sweep, drive rst = 0 for exactly one edge. Required: outputs are 0 for that cycle only, then resume matching the model on the next edge.
- Exhaustive: all 65536 (a,b,c,d) combinations, one per cycle. Required: sum == (a+b+c+d) mod 16 and ov == ((a+b+c+d) > 15) one cycle later, with zero mismatches.
